// File: rtl/fc_argmax_if.sv
// Bus between the pooling stage, the weight ROM and the fully-connected argmax classifier.
// The slave modport is the classifier side; the master modport is the feeding/observing side.
interface fc_argmax_if #(
  parameter int CLS_NUM = 10
);
  logic signed [31:0]        pool_data;
  logic                      pool_data_vld;
  logic [9:0]                w_rd_addr;
  logic [16*CLS_NUM-1:0]     w_rd_data;
  logic [16*CLS_NUM-1:0]     bias_data;
  logic [3:0]                digit_rslt;
  logic                      digit_vld;
  logic                      busy;
  logic                      drop_err;

  modport slave (
    input  pool_data, pool_data_vld, w_rd_data, bias_data,
    output w_rd_addr, digit_rslt, digit_vld, busy, drop_err
  );

  modport master (
    output pool_data, pool_data_vld, w_rd_data, bias_data,
    input  w_rd_addr, digit_rslt, digit_vld, busy, drop_err
  );
endinterface

// File: rtl/fc_argmax.sv
// Fully-connected layer (one MAC per class per feature) followed by bias add and a
// sequential signed argmax over the class scores; one digit_vld pulse per frame.
module fc_argmax #(
  parameter int FEAT_NUM = 864,
  parameter int CLS_NUM  = 10
) (
  input  logic       sclk,
  input  logic       s_rst,
  fc_argmax_if.slave bus
);

  typedef enum logic [1:0] {ACC, BIAS, CMP, DONE} state_e;

  localparam logic [9:0] FEAT_LAST = 10'(FEAT_NUM - 1);
  localparam logic [3:0] CLS_LAST  = 4'(CLS_NUM - 1);

  state_e             state_q, state_d;
  logic [9:0]         feat_cnt_q, feat_cnt_d;
  logic signed [31:0] pd_q, pd_d;
  logic               pvld_q, pvld_d;
  logic               plast_q, plast_d;
  logic signed [47:0] acc_q [CLS_NUM];
  logic signed [47:0] acc_d [CLS_NUM];
  logic [3:0]         cmp_idx_q, cmp_idx_d;
  logic [3:0]         best_q, best_d;
  logic signed [47:0] max_q, max_d;
  logic [3:0]         digit_rslt_q, digit_rslt_d;
  logic               digit_vld_q, digit_vld_d;
  logic               drop_err_q, drop_err_d;

  logic               accept;
  logic               take;
  logic [9:0]         w_rd_addr;
  logic signed [47:0] cand;
  logic signed [15:0] w_k      [CLS_NUM];
  logic signed [15:0] b_k      [CLS_NUM];
  logic signed [47:0] mac_term [CLS_NUM];

  // Per-class product of the registered feature and the weight that arrived this cycle.
  always_comb begin
    for (int k = 0; k < CLS_NUM; k++) begin
      w_k[k]      = bus.w_rd_data[16*k +: 16];
      b_k[k]      = bus.bias_data[16*k +: 16];
      mac_term[k] = (48'(pd_q) * 48'(w_k[k])) >>> 16;
    end
  end

  // NOTE: every variable gets a default before any branch so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    feat_cnt_d   = feat_cnt_q;
    pd_d         = pd_q;
    pvld_d       = 1'b0;
    plast_d      = 1'b0;
    acc_d        = acc_q;
    cmp_idx_d    = cmp_idx_q;
    best_d       = best_q;
    max_d        = max_q;
    digit_rslt_d = digit_rslt_q;
    digit_vld_d  = 1'b0;
    drop_err_d   = drop_err_q;
    w_rd_addr    = '0;
    cand         = '0;
    take         = 1'b0;

    // The cycle right after the final feature is also refused: its MAC would land in BIAS.
    accept = (state_q == ACC) && bus.pool_data_vld && !(pvld_q && plast_q);

    if (bus.pool_data_vld && !accept) drop_err_d = 1'b1;

    if (accept) begin
      w_rd_addr = feat_cnt_q;
      pd_d      = bus.pool_data;
      pvld_d    = 1'b1;
      if (feat_cnt_q == FEAT_LAST) begin
        feat_cnt_d = '0;
        plast_d    = 1'b1;
      end else begin
        feat_cnt_d = feat_cnt_q + 10'd1;
      end
    end

    if (pvld_q) begin
      for (int k = 0; k < CLS_NUM; k++) acc_d[k] = acc_q[k] + mac_term[k];
      if (plast_q) state_d = BIAS;
    end

    case (state_q)
      BIAS: begin
        for (int k = 0; k < CLS_NUM; k++) acc_d[k] = acc_q[k] + 48'(b_k[k]);
        cmp_idx_d = '0;
        state_d   = CMP;
      end
      CMP: begin
        for (int k = 0; k < CLS_NUM; k++) begin
          if (cmp_idx_q == 4'(k)) cand = acc_q[k];
        end
        // Strictly greater keeps the lower index on ties.
        take = (cmp_idx_q == 4'd0) || (cand > max_q);
        if (take) begin
          max_d  = cand;
          best_d = cmp_idx_q;
        end
        if (cmp_idx_q == CLS_LAST) begin
          digit_rslt_d = best_d;
          digit_vld_d  = 1'b1;
          state_d      = DONE;
        end else begin
          cmp_idx_d = cmp_idx_q + 4'd1;
        end
      end
      DONE: begin
        for (int k = 0; k < CLS_NUM; k++) acc_d[k] = '0;
        state_d = ACC;
      end
      default: ;
    endcase
  end

  // NOTE: the accumulators are cleared on reset too, since a new frame must start from zero.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q      <= ACC;
      feat_cnt_q   <= '0;
      pd_q         <= '0;
      pvld_q       <= 1'b0;
      plast_q      <= 1'b0;
      for (int k = 0; k < CLS_NUM; k++) acc_q[k] <= '0;
      cmp_idx_q    <= '0;
      best_q       <= '0;
      max_q        <= '0;
      digit_rslt_q <= '0;
      digit_vld_q  <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      feat_cnt_q   <= feat_cnt_d;
      pd_q         <= pd_d;
      pvld_q       <= pvld_d;
      plast_q      <= plast_d;
      acc_q        <= acc_d;
      cmp_idx_q    <= cmp_idx_d;
      best_q       <= best_d;
      max_q        <= max_d;
      digit_rslt_q <= digit_rslt_d;
      digit_vld_q  <= digit_vld_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign bus.w_rd_addr  = w_rd_addr;
  assign bus.digit_rslt = digit_rslt_q;
  assign bus.digit_vld  = digit_vld_q;
  assign bus.busy       = (state_q != ACC);
  assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax (4 features, 10 classes): expected digits and due cycles
// are queued at stimulus time and checked by an independent monitor on digit_vld.
module tb_fc_argmax;

  localparam int FEAT = 4;
  localparam int CLS  = 10;

  typedef struct {
    logic [3:0] rslt;
    int         due;
  } exp_t;

  typedef logic signed [31:0] frame_t [FEAT];

  logic sclk = 1'b0;
  logic s_rst;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  exp_t             exp_q[$];
  logic [9:0]       addr_log[$];
  logic [16*CLS-1:0] rom [FEAT];

  fc_argmax_if #(.CLS_NUM(CLS)) bus ();

  fc_argmax #(.FEAT_NUM(FEAT), .CLS_NUM(CLS)) dut (
    .sclk  (sclk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  // Weight ROM with one cycle of read latency.
  always @(posedge sclk) bus.w_rd_data <= rom[bus.w_rd_addr[1:0]];

  always @(posedge sclk)
    if (!s_rst && bus.pool_data_vld && !bus.busy) addr_log.push_back(bus.w_rd_addr);

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge sclk) begin
    if (bus.digit_vld) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_digit_vld: got digit %0d, expected no pulse (cycle %0d)",
                 bus.digit_rslt, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("digit_rslt", bus.digit_rslt, e.rslt);
        check("latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic set_weights(input int w [CLS]);
    for (int f = 0; f < FEAT; f++)
      for (int k = 0; k < CLS; k++) rom[f][16*k +: 16] = 16'(w[k]);
  endtask

  task automatic set_bias(input int b [CLS]);
    for (int k = 0; k < CLS; k++) bus.bias_data[16*k +: 16] = 16'(b[k]);
  endtask

  // Called just after a negedge; returns at the negedge following the final feature.
  task automatic send_frame(input frame_t d, input int max_gap, input logic [3:0] exp_rslt);
    int   t_last;
    exp_t e;
    t_last = 0;
    for (int i = 0; i < FEAT; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        bus.pool_data_vld = 1'b0;
        @(negedge sclk);
      end
      bus.pool_data_vld = 1'b1;
      bus.pool_data     = d[i];
      t_last            = cyc;
      @(negedge sclk);
    end
    bus.pool_data_vld = 1'b0;
    e.rslt = exp_rslt;
    e.due  = t_last + 3 + CLS;
    exp_q.push_back(e);
  endtask

  task automatic wait_results();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge sclk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL result_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge sclk);
  endtask

  task automatic check_addrs(input string name);
    check({name, "_count"}, addr_log.size(), FEAT);
    for (int i = 0; i < FEAT && i < addr_log.size(); i++)
      check({name, "_addr"}, addr_log[i], i);
    addr_log.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t unit_f, neg_f, one_f, mix_f;
    unit_f = '{32'sd65536, 32'sd65536, 32'sd65536, 32'sd65536};
    neg_f  = '{-32'sd65536, -32'sd65536, -32'sd65536, -32'sd65536};
    one_f  = '{32'sd1, 32'sd1, 32'sd1, 32'sd1};
    mix_f  = '{32'sd196608, -32'sd65536, 32'sd131072, 32'sd65536};

    s_rst             = 1'b1;
    bus.pool_data_vld = 1'b0;
    bus.pool_data     = '0;
    bus.bias_data     = '0;
    for (int f = 0; f < FEAT; f++) rom[f] = '0;
    repeat (3) @(negedge sclk);
    s_rst = 1'b0;
    @(negedge sclk);

    check("rst_digit_rslt", bus.digit_rslt, 0);
    check("rst_digit_vld", bus.digit_vld, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_drop_err", bus.drop_err, 0);
    check("rst_w_rd_addr", bus.w_rd_addr, 0);

    // Class 3 weighted double: scores 8 versus 4.
    set_weights('{1, 1, 1, 2, 1, 1, 1, 1, 1, 1});
    set_bias('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    send_frame(unit_f, 0, 4'd3);
    wait_results();

    // Bias alone decides; then a tie between classes 2 and 7.
    set_weights('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    set_bias('{0, 0, 0, 0, 0, 10, 0, 0, 0, 0});
    send_frame(unit_f, 0, 4'd5);
    wait_results();
    set_bias('{0, 0, 10, 0, 0, 0, 0, 10, 0, 0});
    send_frame(unit_f, 0, 4'd2);
    wait_results();

    // All negative: class k scores -4(k+1), class 0 is least negative.
    set_weights('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
    set_bias('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    send_frame(neg_f, 0, 4'd0);
    wait_results();

    // (1 * -1) >>> 16 is -1, so class 0 sums to -4 and class 1 wins the zero tie.
    set_weights('{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    send_frame(one_f, 0, 4'd1);
    wait_results();

    // Mixed data: class 6 -> 15, class 9 -> 10, others 5; back-to-back then gapped.
    set_weights('{1, 1, 1, 1, 1, 1, 3, 1, 1, 2});
    addr_log.delete();
    send_frame(mix_f, 0, 4'd6);
    wait_results();
    check_addrs("b2b");
    send_frame(mix_f, 5, 4'd6);
    wait_results();
    check_addrs("gapped");
    repeat (5) @(negedge sclk);
    check("rslt_hold", bus.digit_rslt, 6);

    // Features offered during CMP are dropped without disturbing the frame.
    set_weights('{1, 1, 1, 2, 1, 1, 1, 1, 1, 1});
    send_frame(unit_f, 0, 4'd3);
    repeat (2) @(negedge sclk);
    bus.pool_data_vld = 1'b1;
    bus.pool_data     = 32'sd65536 * 100;
    repeat (5) @(negedge sclk);
    check("busy_in_cmp", bus.busy, 1);
    bus.pool_data_vld = 1'b0;
    wait_results();
    check("drop_err_set", bus.drop_err, 1);
    // Leftover accumulators (class 3 = 8) would beat class 5 here.
    set_weights('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    set_bias('{0, 0, 0, 0, 0, 2, 0, 0, 0, 0});
    send_frame(unit_f, 0, 4'd5);
    wait_results();

    // Reset after two features; aborted frame must never report.
    set_weights('{1, 1, 1, 1, 1, 1, 1, 1, 5, 1});
    set_bias('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    bus.pool_data_vld = 1'b1;
    bus.pool_data     = 32'sd65536;
    repeat (2) @(negedge sclk);
    bus.pool_data_vld = 1'b0;
    s_rst = 1'b1;
    @(negedge sclk);
    s_rst = 1'b0;
    @(negedge sclk);
    check("post_rst_drop_err", bus.drop_err, 0);
    check("post_rst_digit_rslt", bus.digit_rslt, 0);
    check("post_rst_busy", bus.busy, 0);
    addr_log.delete();
    send_frame(unit_f, 0, 4'd8);
    wait_results();
    check_addrs("post_rst");
    check("post_rst_drop_err_end", bus.drop_err, 0);

    repeat (20) @(negedge sclk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
